// File: rtl/cpu_pkg.sv
// Shared types for the datapath sequencer: FSM states, opcode fields, ALU ops.
// Imported by instr_decoder and datapath_sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_PASS = 4'h5
    } alu_op_t;

    // op field values; register ops reuse them as opext
    localparam logic [3:0] OP_REG  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_MOV  = 4'hD;
    localparam logic [3:0] OP_LUI  = 4'hF;
    localparam logic [3:0] EXT_NOP = 4'h0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: IR -> mux selects, ALU op, immediate,
// write classes and illegal flag. The all-zero WAIT word decodes as legal.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  sel_a,
    output logic [3:0]  sel_b,
    output alu_op_t     alu_op,
    output logic        use_imm,
    output logic [15:0] imm,
    output logic        writes_reg,
    output logic        writes_flags,
    output logic        illegal
);

    logic [3:0] op;
    logic [3:0] ext;
    logic [7:0] imm8;

    assign op   = ir[15:12];
    assign ext  = ir[7:4];
    assign imm8 = ir[7:0];

    always_comb begin
        sel_a        = ir[11:8];
        sel_b        = ir[3:0];
        alu_op       = ALU_PASS;
        use_imm      = 1'b0;
        imm          = 16'h0000;
        writes_reg   = 1'b0;
        writes_flags = 1'b0;
        illegal      = 1'b0;
        if (op == OP_REG) begin
            case (ext)
                OP_ADD: begin
                    alu_op = ALU_ADD; writes_reg = 1'b1; writes_flags = 1'b1;
                end
                OP_SUB: begin
                    alu_op = ALU_SUB; writes_reg = 1'b1; writes_flags = 1'b1;
                end
                OP_CMP: begin
                    alu_op = ALU_SUB; writes_flags = 1'b1;
                end
                OP_AND: begin alu_op = ALU_AND;  writes_reg = 1'b1; end
                OP_OR:  begin alu_op = ALU_OR;   writes_reg = 1'b1; end
                OP_XOR: begin alu_op = ALU_XOR;  writes_reg = 1'b1; end
                OP_MOV: begin alu_op = ALU_PASS; writes_reg = 1'b1; end
                // opext 0000 is WAIT only when the whole word is zero
                EXT_NOP: illegal = (ir != 16'h0000);
                default: illegal = 1'b1;
            endcase
        end else begin
            use_imm    = 1'b1;
            writes_reg = 1'b1;
            case (op)
                OP_ADD: begin
                    alu_op = ALU_ADD; imm = {{8{imm8[7]}}, imm8};
                    writes_flags = 1'b1;
                end
                OP_SUB: begin
                    alu_op = ALU_SUB; imm = {{8{imm8[7]}}, imm8};
                    writes_flags = 1'b1;
                end
                OP_CMP: begin
                    alu_op = ALU_SUB; imm = {{8{imm8[7]}}, imm8};
                    writes_flags = 1'b1; writes_reg = 1'b0;
                end
                OP_AND: begin alu_op = ALU_AND;  imm = {8'h00, imm8}; end
                OP_OR:  begin alu_op = ALU_OR;   imm = {8'h00, imm8}; end
                OP_XOR: begin alu_op = ALU_XOR;  imm = {8'h00, imm8}; end
                OP_MOV: begin alu_op = ALU_PASS; imm = {8'h00, imm8}; end
                OP_LUI: begin alu_op = ALU_PASS; imm = {imm8, 8'h00}; end
                default: begin
                    illegal    = 1'b1;
                    use_imm    = 1'b0;
                    writes_reg = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the 16-bit regfile/ALU
// datapath. Ports: clk/reset, start, mem_rdata/mem_ready in; mem_req, pc,
// sel_a/sel_b, use_imm, imm, alu_op, reg_wen, flag_wen, halted, illegal out.
module datapath_sequencer
    import cpu_pkg::*;
#(
    parameter int                   PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  PC_RESET = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] pc,
    output logic [3:0]          sel_a,
    output logic [3:0]          sel_b,
    output logic                use_imm,
    output logic [15:0]         imm,
    output logic [3:0]          alu_op,
    output logic [15:0]         reg_wen,
    output logic                flag_wen,
    output logic                halted,
    output logic                illegal
);

    state_t      state;
    logic [15:0] ir;
    logic [15:0] dec_in;
    logic [3:0]  d_sel_a;
    logic [3:0]  d_sel_b;
    alu_op_t     d_alu_op;
    logic        d_use_imm;
    logic [15:0] d_imm;
    logic        d_writes_reg;
    logic        d_writes_flags;
    logic        d_illegal;

    // In FETCH the incoming word is decoded so the operand fields are
    // registered on the same edge as IR and are valid throughout DECODE.
    assign dec_in = (state == FETCH) ? mem_rdata : ir;

    instr_decoder u_dec (
        .ir           (dec_in),
        .sel_a        (d_sel_a),
        .sel_b        (d_sel_b),
        .alu_op       (d_alu_op),
        .use_imm      (d_use_imm),
        .imm          (d_imm),
        .writes_reg   (d_writes_reg),
        .writes_flags (d_writes_flags),
        .illegal      (d_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= PC_RESET;
            ir       <= 16'h0000;
            mem_req  <= 1'b0;
            sel_a    <= 4'h0;
            sel_b    <= 4'h0;
            use_imm  <= 1'b0;
            imm      <= 16'h0000;
            alu_op   <= ALU_PASS;
            reg_wen  <= 16'h0000;
            flag_wen <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            reg_wen  <= 16'h0000;
            flag_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                        sel_a   <= d_sel_a;
                        sel_b   <= d_sel_b;
                        use_imm <= d_use_imm;
                        imm     <= d_imm;
                        alu_op  <= d_alu_op;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (ir == 16'h0000) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (d_illegal) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        state    <= EXECUTE;
                        reg_wen  <= d_writes_reg ?
                                    (16'h0001 << ir[11:8]) : 16'h0000;
                        flag_wen <= d_writes_flags;
                    end
                end
                EXECUTE: begin
                    pc      <= pc + PC_WIDTH'(1);
                    mem_req <= 1'b1;
                    state   <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed self-checking bench for datapath_sequencer.
// A second instance with PC_RESET=16'hFFFE exercises pc wrap.
module tb_datapath_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    logic        mem_req;
    logic [15:0] pc;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic        use_imm;
    logic [15:0] imm;
    logic [3:0]  alu_op;
    logic [15:0] reg_wen;
    logic        flag_wen;
    logic        halted;
    logic        illegal;

    logic        w_mem_req;
    logic [15:0] w_pc;
    logic [3:0]  w_sel_a;
    logic [3:0]  w_sel_b;
    logic        w_use_imm;
    logic [15:0] w_imm;
    logic [3:0]  w_alu_op;
    logic [15:0] w_reg_wen;
    logic        w_flag_wen;
    logic        w_halted;
    logic        w_illegal;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    datapath_sequencer #(.PC_WIDTH(16), .PC_RESET(16'h0000)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .pc(pc), .sel_a(sel_a), .sel_b(sel_b),
        .use_imm(use_imm), .imm(imm), .alu_op(alu_op),
        .reg_wen(reg_wen), .flag_wen(flag_wen),
        .halted(halted), .illegal(illegal)
    );

    datapath_sequencer #(.PC_WIDTH(16), .PC_RESET(16'hFFFE)) u_wrap (
        .clk(clk), .reset(reset), .start(start),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(w_mem_req), .pc(w_pc), .sel_a(w_sel_a), .sel_b(w_sel_b),
        .use_imm(w_use_imm), .imm(w_imm), .alu_op(w_alu_op),
        .reg_wen(w_reg_wen), .flag_wen(w_flag_wen),
        .halted(w_halted), .illegal(w_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
        step(); step();
        reset = 1'b0;
    endtask

    // present a word with mem_ready high; returns in DECODE
    task automatic issue(input logic [15:0] w);
        mem_rdata = w; mem_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (pc !== 16'h0000) begin
            miscompares++; $display("FAIL reset_pc got %h want 0000", pc);
        end
        vectors++;
        if ({mem_req, halted, illegal, use_imm, flag_wen} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctl got %b want 00000",
                     {mem_req, halted, illegal, use_imm, flag_wen});
        end
        vectors++;
        if ({sel_a, sel_b, imm, reg_wen} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_fields got %h want 0", {sel_a, sel_b, imm, reg_wen});
        end
        vectors++;
        if (alu_op !== ALU_PASS) begin
            miscompares++; $display("FAIL reset_alu got %h want %h", alu_op, ALU_PASS);
        end
    endtask

    task automatic test_add();
        start = 1'b1;
        step();
        vectors++;
        if (mem_req !== 1'b1 || pc !== 16'h0000) begin
            miscompares++; $display("FAIL add_fetch req=%b pc=%h want 1/0000", mem_req, pc);
        end
        issue(16'h0352);
        vectors++;
        if ({sel_a, sel_b} !== 8'h32 || alu_op !== ALU_ADD || use_imm !== 1'b0) begin
            miscompares++;
            $display("FAIL add_decode sel=%h op=%h imm_sel=%b want 32/%h/0",
                     {sel_a, sel_b}, alu_op, use_imm, ALU_ADD);
        end
        vectors++;
        if (reg_wen !== 16'h0000 || flag_wen !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL add_decode_wen wen=%h f=%b req=%b want 0/0/0",
                     reg_wen, flag_wen, mem_req);
        end
        step();
        vectors++;
        if (reg_wen !== 16'h0008 || flag_wen !== 1'b1 || pc !== 16'h0000) begin
            miscompares++;
            $display("FAIL add_exec wen=%h f=%b pc=%h want 0008/1/0000",
                     reg_wen, flag_wen, pc);
        end
        step();
        vectors++;
        if (pc !== 16'h0001 || reg_wen !== 16'h0000 || mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL add_next pc=%h wen=%h req=%b want 0001/0000/1",
                     pc, reg_wen, mem_req);
        end
    endtask

    task automatic test_immediates();
        issue(16'h51FF);
        vectors++;
        if (imm !== 16'hFFFF || use_imm !== 1'b1 || alu_op !== ALU_ADD) begin
            miscompares++;
            $display("FAIL addi_decode imm=%h u=%b op=%h want FFFF/1/%h",
                     imm, use_imm, alu_op, ALU_ADD);
        end
        step();
        vectors++;
        if (reg_wen !== 16'h0002 || flag_wen !== 1'b1) begin
            miscompares++; $display("FAIL addi_exec wen=%h f=%b want 0002/1", reg_wen, flag_wen);
        end
        step();
        issue(16'h11FF);
        vectors++;
        if (imm !== 16'h00FF || alu_op !== ALU_AND || use_imm !== 1'b1) begin
            miscompares++;
            $display("FAIL andi_decode imm=%h op=%h u=%b want 00FF/%h/1",
                     imm, alu_op, use_imm, ALU_AND);
        end
        step();
        vectors++;
        if (reg_wen !== 16'h0002 || flag_wen !== 1'b0) begin
            miscompares++; $display("FAIL andi_exec wen=%h f=%b want 0002/0", reg_wen, flag_wen);
        end
        step();
        issue(16'hF7AB);
        vectors++;
        if (imm !== 16'hAB00 || alu_op !== ALU_PASS || use_imm !== 1'b1) begin
            miscompares++;
            $display("FAIL lui_decode imm=%h op=%h u=%b want AB00/%h/1",
                     imm, alu_op, use_imm, ALU_PASS);
        end
        step();
        vectors++;
        if (reg_wen !== 16'h0080 || flag_wen !== 1'b0) begin
            miscompares++; $display("FAIL lui_exec wen=%h f=%b want 0080/0", reg_wen, flag_wen);
        end
        step();
        vectors++;
        if (pc !== 16'h0004) begin
            miscompares++; $display("FAIL imm_pc got %h want 0004", pc);
        end
    endtask

    task automatic test_cmp_mov();
        issue(16'h04B5);
        vectors++;
        if ({sel_a, sel_b} !== 8'h45 || alu_op !== ALU_SUB || reg_wen !== 16'h0) begin
            miscompares++;
            $display("FAIL cmp_decode sel=%h op=%h wen=%h want 45/%h/0000",
                     {sel_a, sel_b}, alu_op, reg_wen, ALU_SUB);
        end
        step();
        vectors++;
        if (reg_wen !== 16'h0000 || flag_wen !== 1'b1) begin
            miscompares++; $display("FAIL cmp_exec wen=%h f=%b want 0000/1", reg_wen, flag_wen);
        end
        step();
        issue(16'h02D1);
        vectors++;
        if (alu_op !== ALU_PASS || use_imm !== 1'b0 || sel_b !== 4'h1) begin
            miscompares++;
            $display("FAIL mov_decode op=%h u=%b sb=%h want %h/0/1",
                     alu_op, use_imm, sel_b, ALU_PASS);
        end
        step();
        vectors++;
        if (reg_wen !== 16'h0004 || flag_wen !== 1'b0) begin
            miscompares++; $display("FAIL mov_exec wen=%h f=%b want 0004/0", reg_wen, flag_wen);
        end
        step();
        vectors++;
        if (pc !== 16'h0006) begin
            miscompares++; $display("FAIL cmp_mov_pc got %h want 0006", pc);
        end
    endtask

    task automatic test_wait_states();
        mem_ready = 1'b0; mem_rdata = 16'h0352;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (mem_req !== 1'b1 || pc !== 16'h0006 ||
                reg_wen !== 16'h0 || flag_wen !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_%0d req=%b pc=%h wen=%h f=%b want 1/0006/0/0",
                         i, mem_req, pc, reg_wen, flag_wen);
            end
        end
        mem_ready = 1'b1;
        step(); step();
        vectors++;
        if (reg_wen !== 16'h0008 || pc !== 16'h0006) begin
            miscompares++;
            $display("FAIL stall_exec wen=%h pc=%h want 0008/0006", reg_wen, pc);
        end
        step();
        vectors++;
        if (pc !== 16'h0007) begin
            miscompares++; $display("FAIL stall_pc got %h want 0007", pc);
        end
    endtask

    task automatic test_halt();
        issue(16'h0000);
        step();
        vectors++;
        if (halted !== 1'b1 || mem_req !== 1'b0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_halt h=%b req=%b ill=%b want 1/0/0", halted, mem_req, illegal);
        end
        start = 1'b0; step();
        start = 1'b1; step();
        start = 1'b0; step();
        vectors++;
        if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 16'h0007 || reg_wen !== 16'h0) begin
            miscompares++;
            $display("FAIL halt_hold h=%b req=%b pc=%h wen=%h want 1/0/0007/0",
                     halted, mem_req, pc, reg_wen);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        start = 1'b1; step();
        issue(16'hE000);
        step();
        vectors++;
        if (halted !== 1'b1 || illegal !== 1'b1 || reg_wen !== 16'h0) begin
            miscompares++;
            $display("FAIL illegal_op h=%b ill=%b wen=%h want 1/1/0", halted, illegal, reg_wen);
        end
        do_reset();
        vectors++;
        if (illegal !== 1'b0 || halted !== 1'b0) begin
            miscompares++; $display("FAIL illegal_clear ill=%b h=%b want 0/0", illegal, halted);
        end
        start = 1'b1; step();
        issue(16'h0370);
        step();
        vectors++;
        if (halted !== 1'b1 || illegal !== 1'b1) begin
            miscompares++; $display("FAIL illegal_ext h=%b ill=%b want 1/1", halted, illegal);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        start = 1'b1; step();
        issue(16'h0352); step(); step();
        mem_ready = 1'b0; step();
        vectors++;
        if (mem_req !== 1'b1 || pc !== 16'h0001) begin
            miscompares++; $display("FAIL mid_pre req=%b pc=%h want 1/0001", mem_req, pc);
        end
        reset = 1'b1; mem_ready = 1'b1;
        step();
        vectors++;
        if (pc !== 16'h0000 || mem_req !== 1'b0 || reg_wen !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_reset pc=%h req=%b wen=%h want 0000/0/0", pc, mem_req, reg_wen);
        end
        reset = 1'b0; start = 1'b0;
        step(); step();
        vectors++;
        if (mem_req !== 1'b0 || pc !== 16'h0000 || reg_wen !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_idle req=%b pc=%h wen=%h want 0/0000/0", mem_req, pc, reg_wen);
        end
        start = 1'b1; step();
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++; $display("FAIL mid_restart req=%b want 1", mem_req);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        vectors++;
        if (w_pc !== 16'hFFFE) begin
            miscompares++; $display("FAIL wrap_reset pc=%h want FFFE", w_pc);
        end
        start = 1'b1; step();
        issue(16'h0352); step(); step();
        vectors++;
        if (w_pc !== 16'hFFFF) begin
            miscompares++; $display("FAIL wrap_ffff pc=%h want FFFF", w_pc);
        end
        issue(16'h0352); step(); step();
        vectors++;
        if (w_pc !== 16'h0000 || w_mem_req !== 1'b1) begin
            miscompares++; $display("FAIL wrap_zero pc=%h req=%b want 0000/1", w_pc, w_mem_req);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
        test_reset();
        test_add();
        test_immediates();
        test_cmp_mov();
        test_wait_states();
        test_halt();
        test_illegal();
        test_reset_mid_fetch();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
